// File: rtl/sprite_anim_player.sv
// rtl/sprite_anim_player.sv - 8x8 sprite frame sequencer (one-shot/loop/ping-pong)
// Optional horizontal-flip port enabled by defining ANIM_MIRROR_EN.
module sprite_anim_player #(
  parameter int FRAME_W    = 64,
  parameter int ADDR_W     = 4,
  parameter int NUM_FRAMES = 5,
  parameter int TICK_DIV   = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
`ifdef ANIM_MIRROR_EN
  input  logic               mirror,
`endif
  input  logic [ADDR_W-1:0]  first_frame,
  input  logic [ADDR_W-1:0]  last_frame,
  output logic [ADDR_W-1:0]  frame_idx,
  output logic [FRAME_W-1:0] frame_data,
  output logic               busy,
  output logic               done
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [ADDR_W:0] LP_NUM = (ADDR_W + 1)'(NUM_FRAMES);

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t              r_state;
  logic [TW-1:0]       r_tick;
  logic [ADDR_W-1:0]   r_frame_idx;
  logic [FRAME_W-1:0]  r_frame_data;
  logic [ADDR_W-1:0]   r_first;
  logic [ADDR_W-1:0]   r_last;
  logic [1:0]          r_mode;
  logic                r_dir_down;
  logic                r_busy;
  logic                r_done;

  logic                w_start_ok;
  logic [ADDR_W-1:0]   w_start_last;
  logic [ADDR_W-1:0]   w_step_idx;
  logic                w_step_dir_down;
  logic                w_oneshot_end;
  logic [ADDR_W-1:0]   w_load_idx;
  logic [FRAME_W-1:0]  w_rom_data;
  logic [FRAME_W-1:0]  w_load_data;

  function automatic logic [FRAME_W-1:0] rom_read(input logic [ADDR_W-1:0] idx);
    logic [FRAME_W-1:0] v;
    if ({1'b0, idx} >= LP_NUM) begin
      v = '1;
    end else begin
      case (idx)
        ADDR_W'(0): v = FRAME_W'(64'h2854443810141810);
        ADDR_W'(1): v = FRAME_W'(64'h142a221c08281808);
        ADDR_W'(2): v = FRAME_W'(64'h285444381151d9d5);
        ADDR_W'(3): v = FRAME_W'(64'h142a221c888a9bab);
        ADDR_W'(4): v = FRAME_W'(64'h18187e7e18181818);
        default:    v = '1;
      endcase
    end
    return v;
  endfunction

  function automatic logic [FRAME_W-1:0] flip_rows(input logic [FRAME_W-1:0] d);
    logic [FRAME_W-1:0] v;
    v = '0;
    for (int r = 0; r < FRAME_W / 8; r++) begin
      for (int b = 0; b < 8; b++) begin
        v[r*8 + b] = d[r*8 + 7 - b];
      end
    end
    return v;
  endfunction

  // Stop beats start in every state, so a simultaneous pair never restarts.
  assign w_start_ok   = start && !stop;
  assign w_start_last = (first_frame > last_frame) ? first_frame : last_frame;

  always_comb begin
    w_step_idx      = r_frame_idx;
    w_step_dir_down = r_dir_down;
    w_oneshot_end   = 1'b0;
    case (r_mode)
      MODE_ONESHOT: begin
        if (r_frame_idx == r_last) w_oneshot_end = 1'b1;
        else                       w_step_idx = r_frame_idx + 1'b1;
      end
      MODE_PINGPONG: begin
        if (r_first == r_last) begin
          w_step_idx = r_frame_idx;
        end else if (!r_dir_down) begin
          if (r_frame_idx == r_last) begin
            w_step_idx      = r_frame_idx - 1'b1;
            w_step_dir_down = 1'b1;
          end else begin
            w_step_idx = r_frame_idx + 1'b1;
          end
        end else begin
          if (r_frame_idx == r_first) begin
            w_step_idx      = r_frame_idx + 1'b1;
            w_step_dir_down = 1'b0;
          end else begin
            w_step_idx = r_frame_idx - 1'b1;
          end
        end
      end
      default: begin
        if (r_frame_idx == r_last) w_step_idx = r_first;
        else                       w_step_idx = r_frame_idx + 1'b1;
      end
    endcase
  end

  // Bitmap is looked up on the index being loaded so both land on one edge.
  assign w_load_idx = w_start_ok ? first_frame : w_step_idx;
  assign w_rom_data = rom_read(w_load_idx);
`ifdef ANIM_MIRROR_EN
  assign w_load_data = mirror ? flip_rows(w_rom_data) : w_rom_data;
`else
  assign w_load_data = w_rom_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tick       <= '0;
      r_frame_idx  <= '0;
      r_frame_data <= '0;
      r_first      <= '0;
      r_last       <= '0;
      r_mode       <= '0;
      r_dir_down   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop && r_state == S_PLAY) begin
        r_state <= S_IDLE;
        r_tick  <= '0;
        r_busy  <= 1'b0;
      end else if (w_start_ok) begin
        r_state      <= S_PLAY;
        r_tick       <= '0;
        r_mode       <= mode;
        r_first      <= first_frame;
        r_last       <= w_start_last;
        r_dir_down   <= 1'b0;
        r_frame_idx  <= w_load_idx;
        r_frame_data <= w_load_data;
        r_busy       <= 1'b1;
      end else if (r_state == S_PLAY) begin
        if (r_tick == TICK_LAST) begin
          r_tick <= '0;
          if (w_oneshot_end) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_frame_idx  <= w_load_idx;
            r_frame_data <= w_load_data;
            r_dir_down   <= w_step_dir_down;
          end
        end else begin
          r_tick <= r_tick + 1'b1;
        end
      end
    end
  end

  assign frame_idx  = r_frame_idx;
  assign frame_data = r_frame_data;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_sprite_anim_player.sv
// tb/tb_sprite_anim_player.sv - scoreboard bench for sprite_anim_player
// Drives directed and random stimulus; expected outputs come from a play-list model.
module tb_sprite_anim_player;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst, start, stop, mirror;
  logic [1:0]  mode;
  logic [3:0]  first_frame, last_frame;
  logic [3:0]  frame_idx;
  logic [63:0] frame_data;
  logic        busy, done;

  always #5 clk = ~clk;

  sprite_anim_player #(
    .FRAME_W(64), .ADDR_W(4), .NUM_FRAMES(5), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .mode(mode),
`ifdef ANIM_MIRROR_EN
    .mirror(mirror),
`endif
    .first_frame(first_frame),
    .last_frame(last_frame),
    .frame_idx(frame_idx),
    .frame_data(frame_data),
    .busy(busy),
    .done(done)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [63:0] data;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle_n = 0;
  bit   running = 0;

  // Reference model: a play list built at start, walked one entry per TICK_DIV cycles.
  int          m_seq[$];
  int          m_pos, m_age, m_idx;
  bit          m_play, m_oneshot, m_busy, m_done;
  logic [63:0] m_data;

  function automatic logic [63:0] ref_frame(input int idx, input logic mi);
    logic [63:0] rom [5];
    logic [63:0] v, f;
    rom[0] = 64'h2854443810141810;
    rom[1] = 64'h142a221c08281808;
    rom[2] = 64'h285444381151d9d5;
    rom[3] = 64'h142a221c888a9bab;
    rom[4] = 64'h18187e7e18181818;
    v = (idx < 5) ? rom[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
    f = v;
`ifdef ANIM_MIRROR_EN
    if (mi) for (int i = 0; i < 64; i++) f[i] = v[(i / 8) * 8 + 7 - (i % 8)];
`endif
    return (mi === 1'bx) ? v : f;
  endfunction

  task automatic model_edge(input logic r, s, p, input logic [1:0] m,
                            input logic [3:0] f, l, input logic mi);
    int lo, hi;
    m_done = 0;
    if (r) begin
      m_play = 0; m_idx = 0; m_data = '0; m_busy = 0; m_age = 0;
    end else if (p && m_play) begin
      m_play = 0; m_busy = 0;
    end else if (s && !p) begin
      lo = f;
      hi = (f > l) ? f : l;
      m_seq.delete();
      for (int i = lo; i <= hi; i++) m_seq.push_back(i);
      if (m == 2'd2) for (int i = hi - 1; i > lo; i--) m_seq.push_back(i);
      m_oneshot = (m == 2'd0);
      m_pos = 0; m_idx = m_seq[0]; m_data = ref_frame(m_idx, mi);
      m_busy = 1; m_play = 1; m_age = 0;
    end else if (m_play) begin
      m_age++;
      if (m_age == TICK_DIV) begin
        m_age = 0;
        if (m_oneshot && m_pos == m_seq.size() - 1) begin
          m_play = 0; m_busy = 0; m_done = 1;
        end else begin
          m_pos  = (m_pos + 1) % m_seq.size();
          m_idx  = m_seq[m_pos];
          m_data = ref_frame(m_idx, mi);
        end
      end
    end
  endtask

  task automatic cyc(input logic r, s, p, input logic [1:0] m,
                     input logic [3:0] f, l, input logic mi);
    exp_t e;
    @(negedge clk);
    rst = r; start = s; stop = p; mode = m;
    first_frame = f; last_frame = l; mirror = mi;
    model_edge(r, s, p, m, f, l, mi);
    e.idx = 4'(m_idx); e.data = m_data; e.busy = m_busy; e.done = m_done;
    expq.push_back(e);
    running = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'd0, 4'd0, 4'd0, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (running) begin
      cycle_n++;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty cycle %0d: no expected entry", cycle_n);
      end else begin
        e = expq.pop_front();
        if (frame_idx !== e.idx) begin
          errors++;
          $display("FAIL frame_idx cycle %0d: got %0d want %0d", cycle_n, frame_idx, e.idx);
        end
        checks++;
        if (frame_data !== e.data) begin
          errors++;
          $display("FAIL frame_data cycle %0d: got %h want %h", cycle_n, frame_data, e.data);
        end
        checks++;
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL busy cycle %0d: got %b want %b", cycle_n, busy, e.busy);
        end
        checks++;
        if (done !== e.done) begin
          errors++;
          $display("FAIL done cycle %0d: got %b want %b", cycle_n, done, e.done);
        end
      end
    end
  end

  initial begin
    rst = 1; start = 0; stop = 0; mode = 0; first_frame = 0; last_frame = 0; mirror = 0;

    cyc(1, 0, 0, 2'd0, 4'd0, 4'd0, 1'b0);
    cyc(1, 0, 0, 2'd0, 4'd0, 4'd0, 1'b0);
    idle(2);
    cyc(0, 0, 1, 2'd0, 4'd0, 4'd0, 1'b0);           // stop while idle
    idle(1);

    cyc(0, 1, 0, 2'd0, 4'd1, 4'd3, 1'b0);           // one-shot 1..3
    idle(16);
    cyc(0, 1, 0, 2'd1, 4'd0, 4'd2, 1'b0);           // loop 0..2
    idle(22);
    cyc(0, 0, 1, 2'd0, 4'd0, 4'd0, 1'b0);
    idle(2);
    cyc(0, 1, 0, 2'd2, 4'd0, 4'd2, 1'b0);           // ping-pong 0..2
    idle(26);
    cyc(0, 1, 0, 2'd2, 4'd4, 4'd4, 1'b0);           // ping-pong single frame
    idle(10);
    cyc(0, 1, 1, 2'd1, 4'd0, 4'd3, 1'b0);           // start+stop while playing
    idle(3);
    cyc(0, 1, 0, 2'd0, 4'd5, 4'd2, 1'b0);           // first > last, unpopulated frame
    idle(8);
    cyc(0, 1, 0, 2'd3, 4'd1, 4'd4, 1'b0);           // mode 3 loops
    idle(6);
    cyc(0, 1, 0, 2'd0, 4'd2, 4'd4, 1'b0);           // restart mid-play
    idle(5);
    cyc(1, 0, 0, 2'd0, 4'd0, 4'd0, 1'b0);           // reset mid-play
    idle(3);
    cyc(0, 1, 0, 2'd1, 4'd0, 4'd0, 1'b1);           // mirrored frame 0
    idle(5);

    for (int i = 0; i < 2500; i++) begin
      logic r, s, p, mi;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 29) == 0);
      p  = ($urandom_range(0, 39) == 0);
      mi = 1'b0;
`ifdef ANIM_MIRROR_EN
      mi = 1'($urandom_range(0, 1));
`endif
      cyc(r, s, p, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)),
          4'($urandom_range(0, 9)), mi);
    end

    @(posedge clk);
    #2;
    running = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
